led_frame_sched: RTL and testbench
==================================

Name: led_frame_sched

Overview:
- Frame-level sequencer for the 8-strip LED wall serializer.
- Fetches bit-planes from the frame buffer. Each 8-bit word holds one bit position of one LED, for all 8 strips.
- Drives the serializer in three phases per LED bit (force-1 / data / force-0) and paces them off the 200 MHz logic clock.
- After the last bit it holds the lines low for the LED latch/reset gap, then reports frame completion to the frame-buffer owner.

Parameters:
- LEDS_PER_STRIP, 64, LEDs on each of the 8 parallel strips.
- BITS_PER_LED, 24, colour bits per LED, sent MSB-first in address order.
- ADDR_W, 11, frame-buffer address width; must satisfy 2^ADDR_W >= LEDS_PER_STRIP*BITS_PER_LED.
- PHASE_CYC, 83, clk_in cycles per serializer phase; minimum 2.
- LATCH_CYC, 10000, clk_in cycles of all-zero latch gap (50 us at 200 MHz).

Ports:
- clk_in, input, 1, the single logic clock (200 MHz); all logic on its rising edge.
- ar, input, 1, reset; synchronous, active-high.
- start, input, 1, one-cycle frame request; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until the frame_done cycle, exclusive of that cycle.
- frame_done, output, 1, one-cycle pulse when the latch gap ends.
- rd_en, output, 1, frame-buffer read strobe.
- rd_addr, output, ADDR_W, frame-buffer address; holds its value when rd_en is low.
- rd_data, input, 8, frame-buffer word; valid the cycle after rd_en.
- bit_data, output, 8, current bit for strips 7..0, presented to the serializer data input.
- phase, output, 2, serializer phase: 0 = force-1, 1 = data, 2 = force-0, 3 = idle/latch.
- sr_tick, output, 1, one-cycle strobe on the first cycle of every phase.
- line_out, output, 8, composed strip levels: 8'hFF in phase 0, bit_data in phase 1, 8'h00 otherwise.

Behaviour:
- Reset (ar=1 at a clock edge):
  - state to IDLE; all counters cleared.
  - busy=0, frame_done=0, rd_en=0, rd_addr=0, bit_data=0, phase=3, sr_tick=0, line_out=0.
  - Reset mid-frame aborts the frame immediately: no frame_done, and line_out goes low the next cycle.
- States: IDLE -> FETCH -> CAPTURE -> SHIFT -> LATCH -> IDLE.
- IDLE: phase=3. start=1 in cycle T moves to FETCH at T+1. start in any other state is ignored.
- FETCH (cycle T+1): rd_en=1, rd_addr=0, busy=1.
- CAPTURE (cycle T+2): rd_data is registered into prefetch_reg at the end of the cycle.
- SHIFT, entered at T+3:
  - Per bit: phase 0, 1, 2, each lasting PHASE_CYC cycles; sr_tick=1 on the first cycle of each phase.
  - On the first cycle of phase 0: bit_data <= prefetch_reg. If this is not the last bit, assert rd_en with rd_addr = current index + 1; rd_data is captured into prefetch_reg two cycles later.
  - bit_data is stable for the whole bit.
  - Bit index runs 0..N-1, where N = LEDS_PER_STRIP*BITS_PER_LED.
  - After phase 2 of bit N-1 completes, go to LATCH. No read is issued for index N.
- LATCH:
  - phase=3, line_out=0, bit_data=0, for exactly LATCH_CYC cycles.
  - sr_tick=1 on the first LATCH cycle only.
- Done: in the cycle after the last LATCH cycle, the state is IDLE, frame_done=1 and busy=0. A start in that same cycle is accepted.
- Timing:
  - SHIFT length = N*3*PHASE_CYC cycles.
  - Latency from start to frame_done = 3 + N*3*PHASE_CYC + LATCH_CYC cycles.
- Counters:
  - phase_cnt counts 0..PHASE_CYC-1 and wraps.
  - bit index is ADDR_W bits wide and never wraps within a frame.
  - latch_cnt is sized by the synthesis-time clog2(LATCH_CYC).
- rd_en is never high outside FETCH or the phase-0 prefetch cycle. Exactly N reads are issued per frame.

Test Plan:
- Common params: LEDS_PER_STRIP=2, BITS_PER_LED=24 (N=48), PHASE_CYC=4, LATCH_CYC=20.
- Basic frame: buffer word i = i[7:0]; start at cycle T ->
  - first sr_tick at T+3 with bit_data=8'h00;
  - bit 5 starts at T+63 with bit_data=8'h05 and line_out=8'h05 during T+67..T+70;
  - LATCH starts at T+579; frame_done at T+599.
- Read audit over the same frame: exactly 48 rd_en pulses, addresses 0..47 in order, none after LATCH begins; rd_addr held between pulses.
- Waveform: word 8'hA5 at every address -> every bit shows line_out FF (4 cycles), A5 (4 cycles), 00 (4 cycles); phase sequence 0,1,2 repeats; sr_tick every 4 cycles.
- Start while busy: pulse start at T+100 -> ignored; frame_done still at T+599 and only once.
- Back-to-back: start in the frame_done cycle -> new frame accepted; FETCH next cycle; busy high again one cycle after frame_done.
- Reset mid-operation: ar=1 at T+300 for one cycle -> next cycle busy=0, line_out=0, phase=3, rd_en=0; no frame_done; a fresh start then gives a full frame timed as in the basic case.

Source files
------------

// File: rtl/led_frame_sched.sv
// led_frame_sched: frame sequencer for the 8-strip LED serializer.
// It fetches one bit-plane word per LED bit and drives the force-1, data and
// force-0 phases for each bit. After the last bit it holds a latch gap, then
// pulses frame_done.
module led_frame_sched #(
    parameter int unsigned LEDS_PER_STRIP = 64,
    parameter int unsigned BITS_PER_LED   = 24,
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned PHASE_CYC      = 83,
    parameter int unsigned LATCH_CYC      = 10000
) (
    input  logic              clk_in,
    input  logic              ar,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        bit_data,
    output logic [1:0]        phase,
    output logic              sr_tick,
    output logic [7:0]        line_out
);

    localparam int unsigned N_BITS = LEDS_PER_STRIP * BITS_PER_LED;
    localparam int unsigned PCNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int unsigned LCNT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_BITS - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_CYC - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LATCH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [1:0]          ph_q, ph_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;

    logic [7:0]          prefetch_q;
    logic                rd_pend_q;

    logic                bit_start;
    logic                busy_d, done_d, rd_en_d, tick_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [7:0]          bit_data_d, line_d;
    logic [1:0]          phase_d;

    // State and sequencing counters
    always_ff @(posedge clk_in) begin
        if (ar) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            ph_q    <= '0;
            idx_q   <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Next state: phase/bit/latch pacing
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_SHIFT;
                pcnt_d  = '0;
                ph_d    = 2'd0;
                idx_d   = '0;
            end
            S_SHIFT: begin
                if (pcnt_q == PCNT_LAST) begin
                    pcnt_d = '0;
                    if (ph_q == 2'd2) begin
                        ph_d = 2'd0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_LATCH;
                            lcnt_d  = '0;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            S_LATCH: begin
                if (lcnt_q == LCNT_LAST) begin
                    state_d = S_IDLE;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values, decoded from the upcoming state so the outputs land registered
    always_comb begin
        bit_start  = (state_d == S_SHIFT) && (pcnt_d == '0) && (ph_d == 2'd0);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_LATCH) && (state_d == S_IDLE);
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr;
        bit_data_d = 8'h00;
        phase_d    = 2'd3;
        tick_d     = 1'b0;
        line_d     = 8'h00;
        if (state_d == S_FETCH) begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
        end else if (bit_start && (idx_d != LAST_IDX)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = idx_d + ADDR_W'(1);
        end
        if (state_d == S_SHIFT) begin
            phase_d = ph_d;
            tick_d  = (pcnt_d == '0);
            // The first word arrives in the same cycle it is needed, so bypass the prefetch register
            if (bit_start) bit_data_d = rd_pend_q ? rd_data : prefetch_q;
            else           bit_data_d = bit_data;
        end
        if ((state_d == S_LATCH) && (state_q != S_LATCH)) tick_d = 1'b1;
        case (phase_d)
            2'd0:    line_d = 8'hFF;
            2'd1:    line_d = bit_data_d;
            default: line_d = 8'h00;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk_in) begin
        if (ar) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            bit_data   <= 8'h00;
            phase      <= 2'd3;
            sr_tick    <= 1'b0;
            line_out   <= 8'h00;
        end else begin
            busy       <= busy_d;
            frame_done <= done_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            bit_data   <= bit_data_d;
            phase      <= phase_d;
            sr_tick    <= tick_d;
            line_out   <= line_d;
        end
    end

    // Capture read data the cycle after each read strobe
    always_ff @(posedge clk_in) begin
        if (ar) begin
            rd_pend_q  <= 1'b0;
            prefetch_q <= 8'h00;
        end else begin
            rd_pend_q <= rd_en;
            if (rd_pend_q) prefetch_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: a cycle-accurate reference model is derived from
// the frame timeline arithmetic and compared against every DUT output.
module tb_led_frame_sched;

    localparam int unsigned LEDS      = 2;
    localparam int unsigned BPL       = 24;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned PC        = 4;
    localparam int unsigned LC        = 20;
    localparam int N         = LEDS * BPL;
    localparam int SHIFT_LEN = N * 3 * PC;
    localparam int FRAME_LEN = 3 + SHIFT_LEN + LC;
    localparam int VW        = 22 + ADDR_W;

    logic              clk_in;
    logic              ar;
    logic              start;
    logic              busy, frame_done, rd_en, sr_tick;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data, bit_data, line_out;
    logic [1:0]        phase;

    logic [7:0]        mem [N];
    logic [ADDR_W-1:0] exp_addr;
    int                tests;
    int                fails;

    led_frame_sched #(
        .LEDS_PER_STRIP(LEDS),
        .BITS_PER_LED  (BPL),
        .ADDR_W        (ADDR_W),
        .PHASE_CYC     (PC),
        .LATCH_CYC     (LC)
    ) dut (
        .clk_in    (clk_in),
        .ar        (ar),
        .start     (start),
        .busy      (busy),
        .frame_done(frame_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .bit_data  (bit_data),
        .phase     (phase),
        .sr_tick   (sr_tick),
        .line_out  (line_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Frame buffer: one-cycle read latency, noise on the bus when not reading
    always @(posedge clk_in) begin
        if (rd_en && (int'(rd_addr) < N)) rd_data <= mem[int'(rd_addr)];
        else                              rd_data <= 8'($urandom);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic e_busy, input logic e_done,
                             input logic e_rd, input logic [7:0] e_bd, input logic [1:0] e_ph,
                             input logic e_tick, input logic [7:0] e_lo);
        logic [VW-1:0] obs, expv;
        obs  = {busy, frame_done, rd_en, rd_addr, bit_data, phase, sr_tick, line_out};
        expv = {e_busy, e_done, e_rd, exp_addr, e_bd, e_ph, e_tick, e_lo};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (busy,done,rd_en,rd_addr,bit_data,phase,tick,line)",
                   tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check_vec(tag, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 8'h00);
    endtask

    // Expected outputs at cycle offset t after the accepted start
    task automatic check_model(input int t);
        logic       e_busy, e_done, e_rd, e_tick;
        logic [1:0] e_ph;
        logic [7:0] e_bd, e_lo;
        int s, k, p, c;
        e_busy = (t >= 1) && (t < FRAME_LEN);
        e_done = (t == FRAME_LEN);
        e_rd = 1'b0; e_ph = 2'd3; e_tick = 1'b0; e_bd = 8'h00; e_lo = 8'h00;
        if (t == 1) begin
            e_rd = 1'b1;
            exp_addr = '0;
        end else if ((t >= 3) && (t < 3 + SHIFT_LEN)) begin
            s = t - 3;
            k = s / (3 * PC);
            p = (s % (3 * PC)) / PC;
            c = s % PC;
            e_ph   = 2'(p);
            e_tick = (c == 0);
            e_bd   = mem[k];
            e_lo   = (p == 0) ? 8'hFF : ((p == 1) ? mem[k] : 8'h00);
            if ((p == 0) && (c == 0) && (k < N - 1)) begin
                e_rd = 1'b1;
                exp_addr = ADDR_W'(k + 1);
            end
        end else if ((t >= 3 + SHIFT_LEN) && (t < FRAME_LEN)) begin
            e_tick = (t == 3 + SHIFT_LEN);
        end
        check_vec($sformatf("frame_t%0d", t), e_busy, e_done, e_rd, e_bd, e_ph, e_tick, e_lo);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    endtask

    // Caller has start=1 in cycle T; walks the frame, optionally with a stray start,
    // an abort reset, or a chained start in the frame_done cycle
    task automatic run_frame(input int stray_at, input int abort_at, input bit chain);
        int nreads, bad_order;
        nreads = 0;
        bad_order = 0;
        for (int t = 1; t <= FRAME_LEN; t++) begin
            tick();
            start = 1'b0;
            ar    = 1'b0;
            check_model(t);
            if (rd_en) begin
                if (rd_addr !== ADDR_W'(nreads)) bad_order++;
                nreads++;
            end
            if (t == stray_at) start = 1'b1;
            if (t == abort_at) begin
                ar = 1'b1;
                tick();
                ar = 1'b0;
                exp_addr = '0;
                check_idle("after_abort");
                return;
            end
            if ((t == FRAME_LEN) && chain) begin
                fill_random();
                start = 1'b1;
            end
        end
        tests++;
        assert (nreads == N) else begin
            fails++;
            $error("FAIL read_count observed=%0d expected=%0d", nreads, N);
        end
        tests++;
        assert (bad_order == 0) else begin
            fails++;
            $error("FAIL read_order observed=%0d expected=0 out-of-order reads", bad_order);
        end
    endtask

    task automatic idle_gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_idle(tag);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_addr = '0;
        ar = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        tick();
        tick();
        check_idle("reset_state");
        ar = 1'b0;
        idle_gap(3, "idle_after_reset");

        // Basic frame: word i = i
        start = 1'b1;
        run_frame(0, 0, 1'b0);
        idle_gap(int'($urandom_range(1, 5)), "idle_post_basic");

        // Constant A5 waveform
        for (int i = 0; i < N; i++) mem[i] = 8'hA5;
        start = 1'b1;
        run_frame(0, 0, 1'b0);
        idle_gap(int'($urandom_range(1, 5)), "idle_post_a5");

        // Random data, stray start at T+100, then back-to-back frame
        fill_random();
        start = 1'b1;
        run_frame(100, 0, 1'b1);
        run_frame(0, 0, 1'b0);
        idle_gap(int'($urandom_range(2, 6)), "idle_post_chain");

        // Abort with reset at T+300, then a fresh full frame
        fill_random();
        start = 1'b1;
        run_frame(0, 300, 1'b0);
        idle_gap(5, "idle_post_abort");
        fill_random();
        start = 1'b1;
        run_frame(0, 0, 1'b0);
        idle_gap(3, "idle_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
